// File: rtl/conv_filter_scheduler.sv
// Per-channel job sequencer for an external conv engine: fetches {filter,bias},
// resets the engine, waits its fixed latency, and presents each channel result.
module conv_filter_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int F          = 64,
  parameter int OUT_LEN    = 128,
  parameter int MAX_CH     = 16,
  parameter int ENG_LAT    = 67,
  parameter int ADDR_W     = 8,
  parameter int CH_W       = 5
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [CH_W-1:0]                 cfg_num_ch,
  input  logic [ADDR_W-1:0]               cfg_base,
  input  logic                            abort,
  output logic                            busy,
  output logic                            done,
  output logic                            w_rd_en,
  output logic [ADDR_W-1:0]               w_addr,
  input  logic [F*DATA_WIDTH+DATA_WIDTH-1:0] w_rdata,
  output logic                            eng_rst_n,
  output logic [F*DATA_WIDTH-1:0]         eng_filter,
  output logic [DATA_WIDTH-1:0]           eng_bias,
  input  logic [OUT_LEN*DATA_WIDTH-1:0]   eng_result,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [OUT_LEN*DATA_WIDTH-1:0]   out_data,
  output logic [CH_W-1:0]                 out_ch
);

  localparam int CNT_W = $clog2(ENG_LAT + 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] FETCH   = 3'd1;
  localparam logic [2:0] LOAD    = 3'd2;
  localparam logic [2:0] ENG_RST = 3'd3;
  localparam logic [2:0] RUN     = 3'd4;
  localparam logic [2:0] OUT     = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;

  logic [2:0]        state;
  logic [CH_W-1:0]   num_ch;
  logic [ADDR_W-1:0] base;
  logic [CH_W-1:0]   ch;
  logic [CNT_W-1:0]  run_cnt;
  logic [CH_W-1:0]   num_ch_clamped;
  logic [CH_W-1:0]   ch_next;

  always_comb begin
    num_ch_clamped = (cfg_num_ch > CH_W'(MAX_CH)) ? CH_W'(MAX_CH) : cfg_num_ch;
    ch_next        = ch + CH_W'(1);
  end

  // Control outputs decode directly from the state register.
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign w_rd_en   = (state == FETCH);
  assign eng_rst_n = (state == RUN) || (state == OUT);
  assign out_valid = (state == OUT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      num_ch     <= '0;
      base       <= '0;
      ch         <= '0;
      run_cnt    <= '0;
      w_addr     <= '0;
      eng_filter <= '0;
      eng_bias   <= '0;
      out_data   <= '0;
      out_ch     <= '0;
    end else if (abort && (state != IDLE)) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (start) begin
          num_ch <= num_ch_clamped;
          base   <= cfg_base;
          ch     <= '0;
          if (num_ch_clamped == '0) begin
            state <= DONE;
          end else begin
            w_addr <= cfg_base;
            state  <= FETCH;
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          eng_filter <= w_rdata[F*DATA_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
          eng_bias   <= w_rdata[DATA_WIDTH-1:0];
          state      <= ENG_RST;
        end
        ENG_RST: begin
          run_cnt <= '0;
          state   <= RUN;
        end
        RUN: begin
          run_cnt <= run_cnt + CNT_W'(1);
          if (run_cnt == CNT_W'(ENG_LAT)) begin
            out_data <= eng_result;
            out_ch   <= ch;
            state    <= OUT;
          end
        end
        OUT: if (out_ready) begin
          if (ch_next == num_ch) begin
            state <= DONE;
          end else begin
            ch     <= ch_next;
            w_addr <= base + ADDR_W'(ch_next);
            state  <= FETCH;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/conv_filter_scheduler.md
CONV_FILTER_SCHEDULER -- requirements
Module: conv_filter_scheduler

Interface
REQ-001 Parameter DATA_WIDTH, 16, sample/weight word width.
REQ-002 Parameter F, 64, filter taps per output channel.
REQ-003 Parameter OUT_LEN, 128, conv outputs per channel.
REQ-004 Parameter MAX_CH, 16, maximum output channels per job.
REQ-005 Parameter ENG_LAT, 67, cycles from engine reset release to valid eng_result.
REQ-006 Parameter ADDR_W, 8, weight memory address width.
REQ-007 Parameter CH_W, 5, channel count/index width.
REQ-008 clk  input  1  clock; all logic on rising edge.
REQ-009 reset  input  1  asynchronous, active-low.
REQ-010 start  input  1  one-cycle job request; sampled only in IDLE.
REQ-011 cfg_num_ch  input  CH_W  channels in job; latched on accepted start.
REQ-012 cfg_base  input  ADDR_W  weight address of channel 0; latched on accepted start.
REQ-013 abort  input  1  synchronous job cancel.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse at job completion.
REQ-016 w_rd_en  output  1  weight memory read strobe.
REQ-017 w_addr  output  ADDR_W  weight memory address.
REQ-018 w_rdata  input  F*DATA_WIDTH+DATA_WIDTH  {filter, bias}; valid one cycle after w_rd_en.
REQ-019 eng_rst_n  output  1  active-low reset to conv engine.
REQ-020 eng_filter  output  F*DATA_WIDTH  filter held stable to engine.
REQ-021 eng_bias  output  DATA_WIDTH  bias held stable to engine.
REQ-022 eng_result  input  OUT_LEN*DATA_WIDTH  engine output vector.
REQ-023 out_valid  output  1  output channel valid.
REQ-024 out_ready  input  1  downstream accept.
REQ-025 out_data  output  OUT_LEN*DATA_WIDTH  captured channel result.
REQ-026 out_ch  output  CH_W  channel index of out_data.

Function
REQ-027 FSM states SHALL be IDLE, FETCH, LOAD, ENG_RST, RUN, OUT, DONE.
REQ-028 IDLE: start=1 SHALL latch cfg, clear channel index, go FETCH; if latched count is 0 go DONE directly.
REQ-029 cfg_num_ch > MAX_CH SHALL be clamped to MAX_CH at latch.
REQ-030 FETCH (1 cycle): w_rd_en=1, w_addr=(base+ch) mod 2^ADDR_W; next LOAD.
REQ-031 LOAD (1 cycle): register w_rdata into eng_filter/eng_bias; next ENG_RST.
REQ-032 ENG_RST (1 cycle): eng_rst_n=0; clear run counter; next RUN.
REQ-033 RUN: eng_rst_n=1, counter increments each cycle; at counter==ENG_LAT capture eng_result into out_data, out_ch=ch, go OUT.
REQ-034 eng_rst_n SHALL be 0 in IDLE, FETCH, LOAD, ENG_RST, DONE; 1 in RUN and OUT.
REQ-035 OUT: out_valid=1; out_data/out_ch stable until out_valid&&out_ready.
REQ-036 On handshake: if ch+1 == count go DONE, else ch+=1 and go FETCH same next cycle.
REQ-037 Per-channel latency from FETCH to out_valid SHALL be ENG_LAT+4 cycles with out_ready held high.
REQ-038 DONE (1 cycle): done=1, busy=1 low next cycle; next IDLE.
REQ-039 start while busy SHALL be ignored with no effect on latched cfg.
REQ-040 abort=1 in any non-IDLE state SHALL go IDLE next cycle, drop out_valid, no done pulse; abort wins over handshake in same cycle.
REQ-041 w_rd_en SHALL be 0 outside FETCH; w_addr holds last value.
REQ-042 Address wrap: base+ch overflow SHALL wrap modulo 2^ADDR_W without error.

Reset
REQ-043 reset=0 SHALL force IDLE asynchronously: busy=0, done=0, w_rd_en=0, w_addr=0, eng_rst_n=0, eng_filter=0, eng_bias=0, out_valid=0, out_data=0, out_ch=0, counters=0.
REQ-044 reset mid-job SHALL discard the job; no done after release until new start.

Verification
REQ-045 start, cfg_num_ch=3, cfg_base=0x10, out_ready=1 -> reads at 0x10,0x11,0x12; out_ch 0,1,2; out_valid ENG_LAT+4 cycles after each FETCH; one done pulse.
REQ-046 cfg_num_ch=0 -> no w_rd_en, done pulses cycle after start, busy high exactly 1 cycle.
REQ-047 out_ready low 20 cycles in OUT -> out_data/out_ch stable, engine not restarted, next FETCH only after handshake.
REQ-048 cfg_base=0xFE, cfg_num_ch=4 -> addresses 0xFE,0xFF,0x00,0x01.
REQ-049 abort during RUN of channel 1 -> IDLE next cycle, out_valid never rises for channel 1, no done; new start accepted.
REQ-050 reset asserted during OUT, cfg_num_ch=20 on next job -> all outputs at reset values; next job clamps to 16 channels.
